// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a CPU port (m0)
// and a DMA/debug port (m1). Round-robin arbitration, req/ack handshake,
// WAIT_CYCLES extra strobe cycles per access, misaligned-address rejection.
// Every memory-side output and every ack/err/rdata output is a flop.
module dmem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int unsigned   CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    logic [1:0]    state;
    logic          last_gnt;
    logic          gnt;
    logic [CW-1:0] cnt;

    logic          pick_valid;
    logic          pick;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          misaligned;

    // Arbitration: a lone requester wins; on a tie the port opposite last_gnt wins.
    always_comb begin
        pick_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            pick = ~last_gnt;
        end else begin
            pick = m1_req;
        end
        sel_we     = pick ? m1_we    : m0_we;
        sel_addr   = pick ? m1_addr  : m0_addr;
        sel_wdata  = pick ? m1_wdata : m0_wdata;
        misaligned = (sel_addr[1:0] != 2'b00);
    end

    assign busy = (state != IDLE);

    // Main FSM. The mem_* registers double as the latched request: they are
    // loaded on grant, held through ACCESS and cleared when it ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            gnt       <= 1'b0;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt      <= pick;
                        last_gnt <= pick;
                        cnt      <= '0;
                        if (misaligned) begin
                            state <= DONE;
                            if (pick) begin
                                m1_ack <= 1'b1;
                                m1_err <= 1'b1;
                            end else begin
                                m0_ack <= 1'b1;
                                m0_err <= 1'b1;
                            end
                        end else begin
                            state     <= ACCESS;
                            mem_read  <= ~sel_we;
                            mem_write <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (gnt) begin
                            m1_ack <= 1'b1;
                            if (!mem_write) m1_rdata <= mem_rdata;
                        end else begin
                            m0_ack <= 1'b1;
                            if (!mem_write) m0_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance a runs with WAIT_CYCLES=0,
// instance b with WAIT_CYCLES=3, each backed by a small word memory.
module tb_dmem_arbiter;

    logic clk;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance a (WAIT_CYCLES = 0) ----------------
    logic        a_reset;
    logic        a_m0_req, a_m0_we, a_m0_ack, a_m0_err;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
    logic        a_m1_req, a_m1_we, a_m1_ack, a_m1_err;
    logic [31:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
    logic        a_mem_read, a_mem_write, a_busy;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic [31:0] mem_a [16] = '{32'h0, 32'h11111111, 32'hDEADBEEF, 32'hCAFEF00D,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    assign a_mem_rdata = mem_a[a_mem_addr[5:2]];
    always @(posedge clk) if (a_mem_write) mem_a[a_mem_addr[5:2]] <= a_mem_wdata;

    dmem_arbiter #(.WAIT_CYCLES(0), .AW(32), .DW(32)) dut_a (
        .clk(clk), .reset(a_reset),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_ack(a_m0_ack), .m0_err(a_m0_err), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_ack(a_m1_ack), .m1_err(a_m1_err), .m1_rdata(a_m1_rdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    // ---------------- instance b (WAIT_CYCLES = 3) ----------------
    logic        b_reset;
    logic        b_m0_req, b_m0_we, b_m0_ack, b_m0_err;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
    logic        b_m1_req, b_m1_we, b_m1_ack, b_m1_err;
    logic [31:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic        b_mem_read, b_mem_write, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [31:0] mem_b [16] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A50001,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0};

    assign b_mem_rdata = mem_b[b_mem_addr[5:2]];
    always @(posedge clk) if (b_mem_write) mem_b[b_mem_addr[5:2]] <= b_mem_wdata;

    dmem_arbiter #(.WAIT_CYCLES(3), .AW(32), .DW(32)) dut_b (
        .clk(clk), .reset(b_reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("%s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp0;
        logic exp1;
        checks   = 0;
        failures = 0;

        a_reset = 1'b1; b_reset = 1'b1;
        a_m0_req = 1'b0; a_m0_we = 1'b0; a_m0_addr = '0; a_m0_wdata = '0;
        a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = '0; a_m1_wdata = '0;
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy",      32'(a_busy),      32'h0);
        check("rst_mem_read",  32'(a_mem_read),  32'h0);
        check("rst_mem_write", 32'(a_mem_write), 32'h0);
        check("rst_mem_addr",  a_mem_addr,       32'h0);
        check("rst_m0_ack",    32'(a_m0_ack),    32'h0);
        check("rst_m1_ack",    32'(a_m1_ack),    32'h0);
        check("rst_m0_rdata",  a_m0_rdata,       32'h0);
        check("rst_b_busy",    32'(b_busy),      32'h0);
        a_reset = 1'b0; b_reset = 1'b0;

        // Test 1: m0 read 0x8, WAIT=0
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h8;
        tick();
        check("t1_mem_read_c1",  32'(a_mem_read),  32'h1);
        check("t1_mem_write_c1", 32'(a_mem_write), 32'h0);
        check("t1_mem_addr_c1",  a_mem_addr,       32'h8);
        check("t1_busy_c1",      32'(a_busy),      32'h1);
        check("t1_ack_c1",       32'(a_m0_ack),    32'h0);
        tick();
        check("t1_ack_c2",       32'(a_m0_ack),    32'h1);
        check("t1_err_c2",       32'(a_m0_err),    32'h0);
        check("t1_rdata_c2",     a_m0_rdata,       32'hDEADBEEF);
        check("t1_mem_read_c2",  32'(a_mem_read),  32'h0);
        a_m0_req = 1'b0;
        tick();
        check("t1_ack_c3",       32'(a_m0_ack),    32'h0);
        check("t1_busy_c3",      32'(a_busy),      32'h0);
        check("t1_rdata_hold",   a_m0_rdata,       32'hDEADBEEF);

        // Test 2: m1 write 0x10, then m0 reads it back
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'h10; a_m1_wdata = 32'h12345678;
        tick();
        check("t2_mem_write_c1", 32'(a_mem_write), 32'h1);
        check("t2_mem_read_c1",  32'(a_mem_read),  32'h0);
        check("t2_mem_addr_c1",  a_mem_addr,       32'h10);
        check("t2_mem_wdata_c1", a_mem_wdata,      32'h12345678);
        tick();
        check("t2_m1_ack_c2",    32'(a_m1_ack),    32'h1);
        check("t2_m1_err_c2",    32'(a_m1_err),    32'h0);
        check("t2_mem_wdata_c2", a_mem_wdata,      32'h0);
        check("t2_mem_word4",    mem_a[4],         32'h12345678);
        a_m1_req = 1'b0;
        tick();
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h10;
        tick();
        tick();
        check("t2_rd_ack",       32'(a_m0_ack),    32'h1);
        check("t2_rd_rdata",     a_m0_rdata,       32'h12345678);
        a_m0_req = 1'b0;
        tick();

        // Test 3: both requesting after reset, grants alternate m0,m1,m0,m1
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h8;
        a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'hC;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp0 = ((k % 3) == 2) && ((((k - 2) / 3) % 2) == 0);
            exp1 = ((k % 3) == 2) && ((((k - 2) / 3) % 2) == 1);
            check($sformatf("t3_m0_ack_c%0d", k), 32'(a_m0_ack), 32'(exp0));
            check($sformatf("t3_m1_ack_c%0d", k), 32'(a_m1_ack), 32'(exp1));
            if (exp0) check($sformatf("t3_m0_rdata_c%0d", k), a_m0_rdata, 32'hDEADBEEF);
            if (exp1) check($sformatf("t3_m1_rdata_c%0d", k), a_m1_rdata, 32'hCAFEF00D);
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        tick();
        check("t3_busy_after", 32'(a_busy), 32'h0);

        // Test 5: misaligned m1 write 0x6 -> ack+err, no strobe, memory intact
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'h6; a_m1_wdata = 32'hFFFFFFFF;
        tick();
        check("t5_m1_ack",       32'(a_m1_ack),    32'h1);
        check("t5_m1_err",       32'(a_m1_err),    32'h1);
        check("t5_mem_write_c1", 32'(a_mem_write), 32'h0);
        check("t5_busy_c1",      32'(a_busy),      32'h1);
        check("t5_m1_rdata",     a_m1_rdata,       32'hCAFEF00D);
        a_m1_req = 1'b0;
        tick();
        check("t5_m1_ack_c2",    32'(a_m1_ack),    32'h0);
        check("t5_m1_err_c2",    32'(a_m1_err),    32'h0);
        check("t5_mem_write_c2", 32'(a_mem_write), 32'h0);
        check("t5_mem_word1",    mem_a[1],         32'h11111111);

        // Test 4: WAIT=3 m0 read 0x14 -> mem_read cycles 1-4, ack cycle 5
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h14;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("t4_mem_read_c%0d", k), 32'(b_mem_read), 32'(k <= 4));
            check($sformatf("t4_m0_ack_c%0d", k),   32'(b_m0_ack),   32'(k == 5));
            check($sformatf("t4_busy_c%0d", k),     32'(b_busy),     32'(k <= 5));
            if (k == 5) begin
                check("t4_rdata", b_m0_rdata, 32'hA5A50001);
                b_m0_req = 1'b0;
            end
        end

        // Test 6: reset during ACCESS, then the held request is serviced afresh
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h14;
        tick();
        check("t6_mem_read_c1", 32'(b_mem_read), 32'h1);
        tick();
        check("t6_mem_read_c2", 32'(b_mem_read), 32'h1);
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        check("t6_busy_abort",     32'(b_busy),     32'h0);
        check("t6_mem_read_abort", 32'(b_mem_read), 32'h0);
        check("t6_ack_abort",      32'(b_m0_ack),   32'h0);
        check("t6_rdata_abort",    b_m0_rdata,      32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("t6_mem_read_c%0d", k), 32'(b_mem_read), 32'(k <= 4));
            check($sformatf("t6_m0_ack_c%0d", k),   32'(b_m0_ack),   32'(k == 5));
            check($sformatf("t6_busy_c%0d", k),     32'(b_busy),     32'(k <= 5));
            if (k == 5) begin
                check("t6_rdata", b_m0_rdata, 32'hA5A50001);
                b_m0_req = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
